// File: rtl/bitno_stage_pkg.sv
// Shared constants and occupancy-state type for the BitNo stage FIFO.
package bitno_stage_pkg;

  localparam int DEFAULT_BITNO = 7;
  localparam int DEFAULT_DEPTH = 4;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } occ_state_e;

endpackage

// File: rtl/bitno_stage_fifo.sv
// First-word-fall-through FIFO that buffers [BitNo:0] words ahead of the
// BitNo stage. InReady depends only on registered pointers, never on OutReady.
module bitno_stage_fifo
  import bitno_stage_pkg::*;
#(
  parameter int BitNo = DEFAULT_BITNO,
  parameter int Depth = DEFAULT_DEPTH,
  localparam int AW   = $clog2(Depth)
) (
  input  logic           Clock,
  input  logic           Reset,
  input  logic           InValid,
  output logic           InReady,
  input  logic [BitNo:0] InData,
  output logic           OutValid,
  input  logic           OutReady,
  output logic [BitNo:0] OutData,
  output logic [AW:0]    Count,
  output logic           Overflow
);

  localparam logic [AW:0] DepthCnt = (AW+1)'(Depth);

  if ((Depth < 2) || ((Depth & (Depth - 1)) != 0)) begin : g_bad_depth
    $error("bitno_stage_fifo: Depth must be a power of two and >= 2");
  end

  logic [Depth-1:0][BitNo:0] mem_q, mem_d;
  logic [AW:0]               wp_q, wp_d;
  logic [AW:0]               rp_q, rp_d;
  logic                      ovf_q, ovf_d;
  logic                      full, empty, wr_en, rd_en;
  occ_state_e                occ;

  always_comb begin
    // Extra wrap bit distinguishes full from empty when the indices match.
    full  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
    empty = (wp_q == rp_q);
    wr_en = InValid && !full;
    rd_en = !empty && OutReady;

    mem_d = mem_q;
    if (wr_en) mem_d[wp_q[AW-1:0]] = InData;
    wp_d  = wr_en ? wp_q + 1'b1 : wp_q;
    rp_d  = rd_en ? rp_q + 1'b1 : rp_q;
    ovf_d = ovf_q || (InValid && full);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      mem_q <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      mem_q <= mem_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      ovf_q <= ovf_d;
    end
  end

  assign InReady  = !full;
  assign OutValid = !empty;
  assign OutData  = mem_q[rp_q[AW-1:0]];
  assign Count    = wp_q - rp_q;
  assign Overflow = ovf_q;

  always_comb begin
    occ = PARTIAL;
    if (Count == '0)           occ = EMPTY;
    else if (Count == DepthCnt) occ = FULL;
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      assert ((occ == FULL) == full);
      assert ((occ == EMPTY) == empty);
    end
  end

endmodule

// File: tb/tb_bitno_stage_fifo.sv
// Scoreboard bench for bitno_stage_fifo at BitNo=15, Depth=4.
module tb_bitno_stage_fifo;

  localparam int BITNO = 15;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic           Clock = 1'b0;
  logic           Reset;
  logic           InValid;
  logic           InReady;
  logic [BITNO:0] InData;
  logic           OutValid;
  logic           OutReady;
  logic [BITNO:0] OutData;
  logic [AW:0]    Count;
  logic           Overflow;

  bitno_stage_fifo #(.BitNo(BITNO), .Depth(DEPTH)) dut (
    .Clock(Clock), .Reset(Reset),
    .InValid(InValid), .InReady(InReady), .InData(InData),
    .OutValid(OutValid), .OutReady(OutReady), .OutData(OutData),
    .Count(Count), .Overflow(Overflow)
  );

  always #5 Clock = ~Clock;

  int n_tests = 0;
  int n_fail  = 0;
  logic [BITNO:0] sb_q[$];
  int   m_cnt = 0;
  logic m_ovf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One cycle: drive, check outputs against the model at negedge, advance model.
  task automatic step(input logic iv, input logic [BITNO:0] id, input logic ordy);
    logic wr, rd;
    InValid  = iv;
    InData   = id;
    OutReady = ordy;
    @(negedge Clock);
    chk("out_valid", 32'(OutValid), 32'(m_cnt != 0));
    chk("in_ready",  32'(InReady),  32'(m_cnt != DEPTH));
    chk("count",     32'(Count),    32'(m_cnt));
    chk("overflow",  32'(Overflow), 32'(m_ovf));
    if (m_cnt != 0) chk("out_data", 32'(OutData), 32'(sb_q[0]));
    wr = iv && (m_cnt < DEPTH);
    rd = ordy && (m_cnt > 0);
    if (iv && m_cnt == DEPTH) m_ovf = 1'b1;
    if (rd) void'(sb_q.pop_front());
    if (wr) sb_q.push_back(id);
    m_cnt = m_cnt + (wr ? 1 : 0) - (rd ? 1 : 0);
    @(posedge Clock);
    #1;
  endtask

  // Reset edge with handshakes presented; everything must be discarded.
  task automatic reset_edge(input logic iv, input logic [BITNO:0] id, input logic ordy);
    Reset = 1'b1;
    InValid = iv; InData = id; OutReady = ordy;
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    sb_q.delete();
    m_cnt = 0;
    m_ovf = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; InValid = 1'b0; InData = '0; OutReady = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    Reset = 1'b0;
    step(1'b0, '0, 1'b0);
    @(negedge Clock);
    chk("reset_data", 32'(OutData), 32'h0);
    @(posedge Clock); #1;

    // Single word, no read, then drain
    step(1'b1, 16'hA5A5, 1'b0);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);

    // Fill, overflow attempt, drain
    for (int i = 1; i <= 4; i++) step(1'b1, 16'(i), 1'b0);
    step(1'b1, 16'd5, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);

    // Steady read+write at Count=2; pointers wrap several times
    step(1'b1, 16'h0100, 1'b0);
    step(1'b1, 16'h0101, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 16'(16'h0102 + i), 1'b1);
    step(1'b0, '0, 1'b0);

    // Full, one read frees space, a write refills
    step(1'b1, 16'h0200, 1'b0);
    step(1'b1, 16'h0201, 1'b0);
    step(1'b0, '0, 1'b1);
    step(1'b1, 16'h0202, 1'b0);
    step(1'b0, '0, 1'b0);

    // Read+write while empty and while full
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);
    step(1'b1, 16'h0300, 1'b1);
    for (int i = 1; i < 4; i++) step(1'b1, 16'(16'h0300 + i), 1'b0);
    step(1'b1, 16'h03FF, 1'b1);
    step(1'b0, '0, 1'b0);

    // Reset mid-operation at Count=3 with a write presented
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 16'(16'h0400 + i), 1'b0);
    reset_edge(1'b1, 16'hDEAD, 1'b0);
    step(1'b0, '0, 1'b0);

    // Random traffic
    for (int i = 0; i < 200; i++)
      step(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)));
    while (m_cnt != 0) step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bitno_stage_fifo.md
# bitno_stage_fifo

Parameterised synchronous first-word-fall-through FIFO that sits directly upstream of the BitNo-parameterised processing stage. It buffers `[BitNo:0]` words from a valid/ready producer and presents them on `OutData`, which the downstream stage consumes as its `In` bus. The FIFO absorbs bursts and decouples producer stalls from the consumer, with no combinational path from `OutReady` to `InReady`.

## Interface
Parameters:
- `BitNo`, default 7: MSB index of the data word; width is BitNo+1, matching the downstream stage.
- `Depth`, default 4: number of entries; power of two, ≥2.
- `localparam AW`, = $clog2(Depth): pointer width.

Ports (clock and reset):
- `Clock`  in  1  sole clock; all state updates on its rising edge.
- `Reset`  in  1  reset; synchronous, active-high.

Ports (upstream side):
- `InValid`  in  1  producer offers `InData`.
- `InReady`  out  1  FIFO accepts this cycle.
- `InData`  in  BitNo+1  write word.

Ports (downstream side):
- `OutValid`  out  1  `OutData` is valid.
- `OutReady`  in  1  consumer takes `OutData` this cycle.
- `OutData`  out  BitNo+1  head word, connected to the downstream stage's `In`.

Ports (status):
- `Count`  out  AW+1  current occupancy, 0..Depth.
- `Overflow`  out  1  sticky; set when InValid is high while full, cleared only by Reset.

## Operation
- Storage: Depth×(BitNo+1) register array; write pointer `wp` and read pointer `rp`, each AW+1 bits (extra wrap bit).
- Full when the low AW bits are equal and the wrap bits differ. Empty when `wp`==`rp`.
- `InReady` = !full, registered-derived; it does not depend on `OutReady`.
- Write: `InValid && InReady` → mem[wp[AW-1:0]] <= InData, wp++.
- Read: `OutValid && OutReady` → rp++.
- `OutValid` = !empty. `OutData` = mem[rp[AW-1:0]], first-word fall-through.
- Simultaneous read and write are allowed at any occupancy where each is individually legal. `Count` is unchanged.
- Writing while full is refused. The data is not stored, and `Overflow` is set.
- Pointers wrap modulo 2·Depth naturally.
- `Count` = wp − rp, modulo 2^(AW+1).
- State summary:
  - EMPTY: Count 0.
  - PARTIAL: 0<Count<Depth.
  - FULL: Count Depth.
  - Transitions follow write-only (+1) and read-only (−1).
  - Read+write holds the current state, except in EMPTY, where only a write occurs, and in FULL, where only a read occurs.

## Timing
- Reset (synchronous): next edge with Reset=1 sets wp=rp=0, Count=0, Overflow=0. Result: OutValid=0, InReady=1, OutData=X-free (array cleared to 0).
- Reset asserted mid-operation discards all contents at that edge. Handshakes presented in the same cycle are ignored.
- Write-to-read latency: a word written at edge N is visible on OutData/OutValid after edge N, i.e. in cycle N+1. There is no bypass in the empty cycle itself.
- Read-to-space latency: a read at edge N raises InReady in cycle N+1 if the FIFO was full.
- Throughput: one word per cycle sustained with both sides active.
- `OutData` and `OutValid` are stable while `OutValid && !OutReady`.

## Structure
- Shared package `bitno_stage_pkg`: default constants DEFAULT_BITNO=7 and DEFAULT_DEPTH=4, plus an occupancy-state enum {EMPTY, PARTIAL, FULL} used by assertions and coverage.
- No sub-module. Pointer logic and array live in the one module.
- Top-level integration instantiates it as `#(.BitNo(15))` ahead of the stage.
- Elaboration assertion: Depth is a power of two and ≥2.

## Test plan
- Reset → OutValid=0, InReady=1, Count=0, Overflow=0.
- BitNo=15, Depth=4: write 16'hA5A5, OutReady=0 → next cycle OutValid=1, OutData=16'hA5A5, Count=1.
- Write 4 words 1,2,3,4 with no reads → InReady=0, Count=4. A fifth InValid with data 5 → Overflow=1 and word 5 is dropped. Reading yields 1,2,3,4.
- Simultaneous read+write at Count=2 for 10 cycles with incrementing data → Count stays 2, order preserved, pointers wrap cleanly past 2·Depth.
- Full FIFO, assert OutReady one cycle → InReady=1 the next cycle. A write then restores Count=4.
- Count=3 and Reset asserted together with InValid → next cycle Count=0, OutValid=0, and the presented word is not stored.
